data_cache_controller: RTL

Direct-mapped, write-back, write-allocate data cache that sits between the pipeline's memory-access stage and main data memory. It consumes the memory-stage request: read/write strobes, ALU-computed address and store data after byte/half refinement. It returns load data and a stall (`busywait`) that freezes all pipeline registers. On a miss it runs a block write-back/refill handshake with a 128-bit-wide data memory.

---
 rtl/dcache_pkg.sv | 23 ++
 rtl/dcache_line_store.sv | 55 +++++
 rtl/data_cache_controller.sv | 133 +++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared widths, FSM state type and word-select helper for the data cache controller.
package dcache_pkg;

    localparam int BLOCK_W    = 128;
    localparam int WORD_W     = 32;
    localparam int OFFSET_W   = 2;
    localparam int MEM_ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE,
        UPDATE
    } dcache_state_e;

    function automatic logic [WORD_W-1:0] select_word(
        input logic [BLOCK_W-1:0]  block,
        input logic [OFFSET_W-1:0] off
    );
        return block[off*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays of the direct-mapped cache: combinational indexed read,
// a word-write port (marks the line dirty) and a block-write port (installs a clean line).
module dcache_line_store
    import dcache_pkg::*;
#(
    parameter int SETS  = 8,
    parameter int IW    = $clog2(SETS),
    parameter int TAG_W = 32 - 4 - IW
)(
    input  logic                clk,
    input  logic                rst,
    input  logic [IW-1:0]       idx,
    output logic                rd_valid,
    output logic                rd_dirty,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [BLOCK_W-1:0]  rd_data,
    input  logic                word_we,
    input  logic [OFFSET_W-1:0] word_off,
    input  logic [WORD_W-1:0]   word_data,
    input  logic                blk_we,
    input  logic [TAG_W-1:0]    blk_tag,
    input  logic [BLOCK_W-1:0]  blk_data
);

    logic [SETS-1:0]    valid_q;
    logic [SETS-1:0]    dirty_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [BLOCK_W-1:0] data_q [SETS];

    // A refill wins over a store; the FSM never asserts both in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (blk_we) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            tag_q[idx]   <= blk_tag;
            data_q[idx]  <= blk_data;
        end else if (word_we) begin
            dirty_q[idx] <= 1'b1;
            data_q[idx][word_off*WORD_W +: WORD_W] <= word_data;
        end
    end

    assign rd_valid = valid_q[idx];
    assign rd_dirty = dirty_q[idx];
    assign rd_tag   = tag_q[idx];
    assign rd_data  = data_q[idx];

endmodule

// File: rtl/data_cache_controller.sv
// Direct-mapped write-back/write-allocate data cache with a 128-bit block memory handshake.
// Optional hit/miss counter ports are added when DCACHE_STATS_EN is defined.
module data_cache_controller
    import dcache_pkg::*;
#(
    parameter int SETS = 8
)(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic [31:0]           address,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_address,
    output logic [BLOCK_W-1:0]    mem_writedata,
    input  logic [BLOCK_W-1:0]    mem_readdata,
    input  logic                  mem_busywait
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`endif
);

    localparam int IW    = $clog2(SETS);
    localparam int TAG_W = 32 - 4 - IW;

    dcache_state_e state_q;
    dcache_state_e state_d;

    logic [IW-1:0]      addr_idx;
    logic [TAG_W-1:0]   addr_tag;
    logic               line_valid;
    logic               line_dirty;
    logic [TAG_W-1:0]   line_tag;
    logic [BLOCK_W-1:0] line_data;
    logic               word_we;
    logic               blk_we;
    logic               hit;
    logic               request;
    logic               unused_addr_bits;

    assign addr_idx         = address[4+IW-1:4];
    assign addr_tag         = address[31:4+IW];
    assign unused_addr_bits = ^address[1:0];

    dcache_line_store #(
        .SETS  (SETS),
        .IW    (IW),
        .TAG_W (TAG_W)
    ) u_line_store (
        .clk       (CLK),
        .rst       (RESET),
        .idx       (addr_idx),
        .rd_valid  (line_valid),
        .rd_dirty  (line_dirty),
        .rd_tag    (line_tag),
        .rd_data   (line_data),
        .word_we   (word_we),
        .word_off  (address[3:2]),
        .word_data (writedata),
        .blk_we    (blk_we),
        .blk_tag   (addr_tag),
        .blk_data  (mem_readdata)
    );

    assign hit      = line_valid && (line_tag == addr_tag);
    assign request  = memRead || memWrite;
    assign busywait = request && ((state_q != IDLE) || !hit);
    assign readdata = memRead ? select_word(line_data, address[3:2]) : '0;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Once a miss leaves IDLE the refill runs to completion even if the strobes drop.
    always_comb begin
        state_d       = state_q;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        mem_address   = '0;
        mem_writedata = '0;
        word_we       = 1'b0;
        blk_we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (request && !hit) begin
                    state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                end else if (memWrite && hit) begin
                    word_we = 1'b1;
                end
            end
            WRITEBACK: begin
                mem_write     = 1'b1;
                mem_address   = {line_tag, addr_idx};
                mem_writedata = line_data;
                if (!mem_busywait) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                mem_read    = 1'b1;
                mem_address = address[31:4];
                if (!mem_busywait) state_d = UPDATE;
            end
            UPDATE: begin
                blk_we  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef DCACHE_STATS_EN
    // A miss is counted when it leaves IDLE; its eventual hit is counted separately.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if ((state_q == IDLE) && request) begin
            if (hit) hit_count  <= hit_count + 32'd1;
            else     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule
